// File: rtl/ir_prefetch_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg
// Shared types and helpers for the IR prefetch / DRAM dispatch stage.
//   dram_word_t  : field layout of one dispatch RAM word (A, B, PAR, J, JX)
//   disp_state_t : lookup sequencer states
//   OPC_JRST     : opcode that takes its J field from the AC bits
//   dram_addr_f  : dispatch RAM address formation from an IR word
// Bit numbering follows the machine documents: IR bit 0 is the MSB, so
// IR[k] lives at vector index 12-k of a 13-bit word.
// ----------------------------------------------------------------------------
package ir_pkg;

    localparam int LAT_W = 3;

    localparam logic [8:0] OPC_JRST = 9'o254;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } disp_state_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       par;
        logic [3:0] j;
        logic [3:0] jx;
    } dram_word_t;

    // I/O class opcodes (IR[0:2] == 7) fold the device field into the
    // address when the diagnostic enable is on: IR[7:9] is forced to all
    // ones when IR[3:6] are all ones, and IR[3:6] themselves drop out.
    function automatic logic [8:0] dram_addr_f(input logic [12:0] ir_w,
                                               input logic        io_en);
        logic       io7;
        logic [2:0] mid;
        io7 = (ir_w[12:10] == 3'o7) && io_en;
        mid = ir_w[5:3] | {3{&ir_w[9:6]}};
        if (io7) begin
            return {ir_w[12:10], mid, ir_w[2:0]};
        end
        return ir_w[12:4];
    endfunction

endpackage

// File: rtl/ir_prefetch_dispatch_fifo.sv
// ----------------------------------------------------------------------------
// ir_fifo
// DEPTH x WIDTH first-word-fall-through queue with an occupancy count.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   clear           : synchronous empty (pointers and count to zero)
//   push / wdata    : write a word when not full
//   pop  / rdata    : rdata always shows the head; pop advances when not empty
//   count           : current occupancy, 0..DEPTH
//   full / empty    : occupancy flags derived from count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module ir_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array needs no reset; only slots behind the count are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and count bookkeeping. A simultaneous push and pop moves both
    // pointers and leaves the count alone. Clear beats any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ir_prefetch_dispatch.sv
// ----------------------------------------------------------------------------
// ir_prefetch_dispatch
// Instruction register with a prefetch queue ahead of it and a sequenced
// lookup into an external dispatch RAM. One dispatch result is held with a
// valid/ack handshake until the consumer takes it.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   in_valid / in_ready / in_word   : instruction word source
//   flush                           : drop queue and any lookup in progress
//   en_io_jrst_set/clr, en_ac_set/clr : sticky diagnostic enables
//   dram_en / dram_addr / dram_rdata: dispatch RAM read port
//   disp_valid / disp_ack           : held result handshake
//   ir, ac                          : current IR and (gated) AC field
//   dram_a, dram_b, dram_j          : captured dispatch fields
//   jrst0                           : IR is exactly 254,0
//   par_err                         : captured word had even parity
//   q_count                         : prefetch queue occupancy
// Field layout is fixed: IR 13 bits, dispatch word 15 bits, address 9 bits.
// ----------------------------------------------------------------------------
module ir_prefetch_dispatch
    import ir_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int IR_WIDTH       = 13,
    parameter int DRAM_WIDTH     = 15,
    parameter int DRAM_ADDR_BITS = 9,
    parameter int DRAM_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IR_WIDTH-1:0]       in_word,
    input  logic                      flush,
    input  logic                      en_io_jrst_set,
    input  logic                      en_io_jrst_clr,
    input  logic                      en_ac_set,
    input  logic                      en_ac_clr,
    output logic                      dram_en,
    output logic [DRAM_ADDR_BITS-1:0] dram_addr,
    input  logic [DRAM_WIDTH-1:0]     dram_rdata,
    output logic                      disp_valid,
    input  logic                      disp_ack,
    output logic [IR_WIDTH-1:0]       ir,
    output logic [3:0]                ac,
    output logic [2:0]                dram_a,
    output logic [2:0]                dram_b,
    output logic [3:0]                dram_j,
    output logic                      jrst0,
    output logic                      par_err,
    output logic [$clog2(DEPTH):0]    q_count
);

    disp_state_t         state;
    disp_state_t         state_nxt;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IR_WIDTH-1:0] head_word;
    logic                push;
    logic                pop;
    logic                capture;
    logic                lat_done;
    logic                en_io_jrst;
    logic                en_ac;
    logic                ir_io_en;
    logic [LAT_W-1:0]    lat_cnt;
    dram_word_t          rword;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready & ~flush;
    assign rword    = dram_word_t'(dram_rdata);
    assign lat_done = (lat_cnt == LAT_W'(1));

    ir_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .wdata (in_word),
        .pop   (pop),
        .rdata (head_word),
        .count (q_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky diagnostic enables. Clear has priority over a same-cycle set.
    // They are only sampled when a word is loaded into the IR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_io_jrst <= 1'b0;
            en_ac      <= 1'b0;
        end else begin
            if (en_io_jrst_clr) begin
                en_io_jrst <= 1'b0;
            end else if (en_io_jrst_set) begin
                en_io_jrst <= 1'b1;
            end
            if (en_ac_clr) begin
                en_ac <= 1'b0;
            end else if (en_ac_set) begin
                en_ac <= 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. An ack with more work queued goes straight back to
    // ISSUE so back-to-back dispatches skip the IDLE cycle. Flush always
    // lands in IDLE regardless of where the lookup was.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_done) state_nxt = HOLD;
            HOLD:    if (disp_ack) state_nxt = fifo_empty ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Per-state control. Flush suppresses the pop (so ir/ac keep their
    // values), the RAM strobe and the capture of any returning data.
    always_comb begin
        pop        = 1'b0;
        capture    = 1'b0;
        dram_en    = 1'b0;
        disp_valid = 1'b0;
        case (state)
            IDLE:  pop = ~fifo_empty;
            ISSUE: dram_en = 1'b1;
            WAIT:  capture = lat_done;
            HOLD: begin
                disp_valid = 1'b1;
                pop        = disp_ack & ~fifo_empty;
            end
            default: ;
        endcase
        if (flush) begin
            pop     = 1'b0;
            capture = 1'b0;
            dram_en = 1'b0;
        end
    end

    // IR load, latency countdown and dispatch capture. The io enable is
    // latched alongside the IR so the address stays consistent for the
    // whole lookup even if the enable is toggled mid-flight. The counter is
    // loaded in ISSUE and the capture fires on the WAIT cycle where it
    // would reach zero, which is DRAM_LATENCY cycles after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir       <= '0;
            ac       <= '0;
            ir_io_en <= 1'b0;
            lat_cnt  <= '0;
            dram_a   <= '0;
            dram_b   <= '0;
            dram_j   <= '0;
            par_err  <= 1'b0;
        end else begin
            if (pop) begin
                ir       <= head_word;
                ac       <= en_ac ? head_word[3:0] : 4'd0;
                ir_io_en <= en_io_jrst;
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_W'(DRAM_LATENCY);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (capture) begin
                dram_a  <= rword.a;
                dram_b  <= rword.b;
                dram_j  <= (ir[12:4] == OPC_JRST) ? ir[3:0] : rword.jx;
                par_err <= ~^rword;
            end
        end
    end

    assign dram_addr = dram_addr_f(ir, ir_io_en);
    assign jrst0     = (ir == {OPC_JRST, 4'd0});

endmodule

// File: tb/tb_ir_prefetch_dispatch.sv
// ----------------------------------------------------------------------------
// tb_ir_prefetch_dispatch
// Directed bench for ir_prefetch_dispatch. Two instances share the input
// stimulus: u_dut with a one-cycle RAM and u_dut3 with a three-cycle RAM.
// A small RAM model returns ram_word exactly DRAM_LATENCY cycles after each
// strobe and zero at every other time.
// ----------------------------------------------------------------------------
module tb_ir_prefetch_dispatch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [12:0] in_word;
    logic        flush;
    logic        en_io_jrst_set;
    logic        en_io_jrst_clr;
    logic        en_ac_set;
    logic        en_ac_clr;
    logic        disp_ack;

    logic        in_ready;
    logic        dram_en;
    logic [8:0]  dram_addr;
    logic [14:0] dram_rdata;
    logic        disp_valid;
    logic [12:0] ir;
    logic [3:0]  ac;
    logic [2:0]  dram_a;
    logic [2:0]  dram_b;
    logic [3:0]  dram_j;
    logic        jrst0;
    logic        par_err;
    logic [2:0]  q_count;

    logic        in_ready3;
    logic        dram_en3;
    logic [8:0]  dram_addr3;
    logic [14:0] dram_rdata3;
    logic        disp_valid3;
    logic [12:0] ir3;
    logic [3:0]  ac3;
    logic [2:0]  dram_a3;
    logic [2:0]  dram_b3;
    logic [3:0]  dram_j3;
    logic        jrst03;
    logic        par_err3;
    logic [2:0]  q_count3;

    logic [14:0] ram_word;
    logic        pipe1;
    logic [2:0]  pipe3;
    logic [12:0] words [6];

    int check_count = 0;
    int pass_count  = 0;

    ir_prefetch_dispatch #(.DEPTH(4), .DRAM_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .flush(flush),
        .en_io_jrst_set(en_io_jrst_set), .en_io_jrst_clr(en_io_jrst_clr),
        .en_ac_set(en_ac_set), .en_ac_clr(en_ac_clr),
        .dram_en(dram_en), .dram_addr(dram_addr), .dram_rdata(dram_rdata),
        .disp_valid(disp_valid), .disp_ack(disp_ack), .ir(ir), .ac(ac),
        .dram_a(dram_a), .dram_b(dram_b), .dram_j(dram_j), .jrst0(jrst0),
        .par_err(par_err), .q_count(q_count)
    );

    ir_prefetch_dispatch #(.DEPTH(4), .DRAM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .in_word(in_word), .flush(flush),
        .en_io_jrst_set(en_io_jrst_set), .en_io_jrst_clr(en_io_jrst_clr),
        .en_ac_set(en_ac_set), .en_ac_clr(en_ac_clr),
        .dram_en(dram_en3), .dram_addr(dram_addr3), .dram_rdata(dram_rdata3),
        .disp_valid(disp_valid3), .disp_ack(disp_ack), .ir(ir3), .ac(ac3),
        .dram_a(dram_a3), .dram_b(dram_b3), .dram_j(dram_j3), .jrst0(jrst03),
        .par_err(par_err3), .q_count(q_count3)
    );

    always #5 clk = ~clk;

    // RAM model: data is presented only in the cycle it is due.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe1 <= 1'b0;
            pipe3 <= 3'b000;
        end else begin
            pipe1 <= dram_en;
            pipe3 <= {pipe3[1:0], dram_en3};
        end
    end

    assign dram_rdata  = pipe1    ? ram_word : 15'h0;
    assign dram_rdata3 = pipe3[2] ? ram_word : 15'h0;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    task applyStimulus(input logic [12:0] word);
        in_valid = 1'b1;
        in_word  = word;
        tick;
        in_valid = 1'b0;
    endtask

    task waitDisp(input string tag);
        int n;
        n = 0;
        while (!disp_valid && n < 20) begin
            tick;
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(disp_valid), 32'd1);
    endtask

    task ackDisp;
        disp_ack = 1'b1;
        tick;
        disp_ack = 1'b0;
    endtask

    // One isolated dispatch on the single-latency instance, starting idle.
    task runDispatch(input string tag, input logic [12:0] word, input logic [8:0] exp_addr,
                     input logic [3:0] exp_ac, input logic [2:0] exp_a, input logic [2:0] exp_b,
                     input logic [3:0] exp_j, input logic exp_par, input logic exp_jrst0);
        int n;
        applyStimulus(word);
        n = 0;
        while (!dram_en && n < 10) begin
            tick;
            n++;
        end
        checkOutput({tag, "_dram_en"}, 32'(dram_en), 32'd1);
        checkOutput({tag, "_addr"}, 32'(dram_addr), 32'(exp_addr));
        waitDisp(tag);
        checkOutput({tag, "_ir"}, 32'(ir), 32'(word));
        checkOutput({tag, "_ac"}, 32'(ac), 32'(exp_ac));
        checkOutput({tag, "_a"}, 32'(dram_a), 32'(exp_a));
        checkOutput({tag, "_b"}, 32'(dram_b), 32'(exp_b));
        checkOutput({tag, "_j"}, 32'(dram_j), 32'(exp_j));
        checkOutput({tag, "_par"}, 32'(par_err), 32'(exp_par));
        checkOutput({tag, "_jrst0"}, 32'(jrst0), 32'(exp_jrst0));
        ackDisp;
        checkOutput({tag, "_drop"}, 32'(disp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_count, check_count);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clk            = 1'b0;
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_word        = '0;
        flush          = 1'b0;
        en_io_jrst_set = 1'b0;
        en_io_jrst_clr = 1'b0;
        en_ac_set      = 1'b0;
        en_ac_clr      = 1'b0;
        disp_ack       = 1'b0;
        ram_word       = 15'b101_011_1_0110_1100;
        tick;
        tick;
        reset = 1'b0;
        tick;

        // Reset state
        checkOutput("rst_q_count", 32'(q_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_disp_valid", 32'(disp_valid), 32'd0);
        checkOutput("rst_dram_en", 32'(dram_en), 32'd0);
        checkOutput("rst_ir", 32'(ir), 32'd0);
        checkOutput("rst_ac", 32'(ac), 32'd0);
        checkOutput("rst_par_err", 32'(par_err), 32'd0);
        checkOutput("rst_jrst0", 32'(jrst0), 32'd0);
        checkOutput("rst_addr", 32'(dram_addr), 32'd0);

        // In-order dispatch, cycle timing and queue draining 3,2,1,0
        words[0] = {9'o200, 4'd1};
        words[1] = {9'o201, 4'd2};
        words[2] = {9'o202, 4'd3};
        words[3] = {9'o203, 4'd4};
        in_valid = 1'b1;
        in_word  = words[0];
        tick;
        checkOutput("seq_cnt_e1", 32'(q_count), 32'd1);
        checkOutput("seq_en_e1", 32'(dram_en), 32'd0);
        in_word = words[1];
        tick;
        checkOutput("seq_ir_e2", 32'(ir), 32'(words[0]));
        checkOutput("seq_en_e2", 32'(dram_en), 32'd1);
        checkOutput("seq_addr_e2", 32'(dram_addr), 32'o200);
        checkOutput("seq_cnt_e2", 32'(q_count), 32'd1);
        in_word = words[2];
        tick;
        checkOutput("seq_en_e3", 32'(dram_en), 32'd0);
        checkOutput("seq_valid_e3", 32'(disp_valid), 32'd0);
        in_word = words[3];
        tick;
        in_valid = 1'b0;
        checkOutput("seq_valid_e4", 32'(disp_valid), 32'd1);
        checkOutput("seq_cnt_e4", 32'(q_count), 32'd3);
        checkOutput("seq_a", 32'(dram_a), 32'd5);
        checkOutput("seq_b", 32'(dram_b), 32'd3);
        checkOutput("seq_j", 32'(dram_j), 32'b1100);
        checkOutput("seq_par", 32'(par_err), 32'd0);
        checkOutput("seq_ac", 32'(ac), 32'd0);
        for (int k = 1; k < 4; k++) begin
            ackDisp;
            checkOutput("seq_ir_pop", 32'(ir), 32'(words[k]));
            checkOutput("seq_cnt_pop", 32'(q_count), 32'(3 - k));
            checkOutput("seq_valid_pop", 32'(disp_valid), 32'd0);
            waitDisp("seq_next");
        end
        ackDisp;
        checkOutput("seq_end_valid", 32'(disp_valid), 32'd0);
        checkOutput("seq_end_cnt", 32'(q_count), 32'd0);

        // Address formation with and without the io/jrst enable
        en_io_jrst_set = 1'b1;
        tick;
        en_io_jrst_set = 1'b0;
        runDispatch("io710", {9'o710, 4'd3}, 9'o703, 4'd0, 3'd5, 3'd3, 4'b1100, 1'b0, 1'b0);
        runDispatch("io774", {9'o774, 4'd5}, 9'o775, 4'd0, 3'd5, 3'd3, 4'b1100, 1'b0, 1'b0);
        en_io_jrst_clr = 1'b1;
        tick;
        en_io_jrst_clr = 1'b0;
        runDispatch("plain710", {9'o710, 4'd3}, 9'o710, 4'd0, 3'd5, 3'd3, 4'b1100, 1'b0, 1'b0);

        // JRST takes J from AC bits; AC gating follows en_ac; clr beats set
        ram_word  = 15'b000_000_1_0000_1010;
        en_ac_set = 1'b1;
        tick;
        en_ac_set = 1'b0;
        runDispatch("jrst", {9'o254, 4'd0}, 9'o254, 4'd0, 3'd0, 3'd0, 4'b0000, 1'b0, 1'b1);
        runDispatch("op200", {9'o200, 4'd5}, 9'o200, 4'd5, 3'd0, 3'd0, 4'b1010, 1'b0, 1'b0);
        en_ac_set = 1'b1;
        en_ac_clr = 1'b1;
        tick;
        en_ac_set = 1'b0;
        en_ac_clr = 1'b0;
        runDispatch("acclr", {9'o200, 4'd7}, 9'o200, 4'd0, 3'd0, 3'd0, 4'b1010, 1'b0, 1'b0);

        // Fill the queue while the result is held; sixth word waits for ack
        for (int i = 0; i < 6; i++) begin
            words[i] = {9'(9'o100 + i), 4'(i)};
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_word = words[i];
            tick;
        end
        checkOutput("fill_cnt4", 32'(q_count), 32'd4);
        checkOutput("fill_ready0", 32'(in_ready), 32'd0);
        checkOutput("fill_ir0", 32'(ir), 32'(words[0]));
        checkOutput("fill_valid", 32'(disp_valid), 32'd1);
        in_word = words[5];
        tick;
        tick;
        checkOutput("fill_refused_cnt", 32'(q_count), 32'd4);
        checkOutput("fill_refused_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_held_ir", 32'(ir), 32'(words[0]));
        checkOutput("fill_held_valid", 32'(disp_valid), 32'd1);
        disp_ack = 1'b1;
        tick;
        disp_ack = 1'b0;
        checkOutput("fill_ack_ir", 32'(ir), 32'(words[1]));
        checkOutput("fill_ack_cnt", 32'(q_count), 32'd3);
        tick;
        in_valid = 1'b0;
        checkOutput("fill_late_push", 32'(q_count), 32'd4);
        for (int k = 1; k < 6; k++) begin
            waitDisp("drain");
            checkOutput("drain_ir", 32'(ir), 32'(words[k]));
            ackDisp;
        end
        checkOutput("drain_cnt", 32'(q_count), 32'd0);
        checkOutput("drain_valid", 32'(disp_valid), 32'd0);

        // Parity over the captured word
        ram_word = 15'h0003;
        runDispatch("par_even", {9'o200, 4'd0}, 9'o200, 4'd0, 3'd0, 3'd0, 4'b0011, 1'b1, 1'b0);
        ram_word = 15'h0001;
        runDispatch("par_odd", {9'o200, 4'd0}, 9'o200, 4'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0);

        // Flush during WAIT on the three-cycle instance
        flush = 1'b1;
        tick;
        flush = 1'b0;
        tick;
        tick;
        tick;
        checkOutput("fl_pre_cnt", 32'(q_count3), 32'd0);
        checkOutput("fl_pre_valid", 32'(disp_valid3), 32'd0);
        ram_word = 15'b101_011_1_0110_1100;
        in_valid = 1'b1;
        in_word  = {9'o300, 4'd1};
        tick;
        in_word = {9'o301, 4'd2};
        tick;
        in_valid = 1'b0;
        checkOutput("fl_issue_en", 32'(dram_en3), 32'd1);
        tick;
        checkOutput("fl_wait_ir", 32'(ir3), 32'({9'o300, 4'd1}));
        checkOutput("fl_wait_cnt", 32'(q_count3), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = {9'o302, 4'd3};
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_cnt", 32'(q_count3), 32'd0);
        checkOutput("fl_valid", 32'(disp_valid3), 32'd0);
        checkOutput("fl_ir_kept", 32'(ir3), 32'({9'o300, 4'd1}));
        for (int k = 0; k < 6; k++) begin
            tick;
            checkOutput("fl_after_valid", 32'(disp_valid3), 32'd0);
            checkOutput("fl_after_en", 32'(dram_en3), 32'd0);
        end

        // Asynchronous reset in the middle of a lookup
        in_valid = 1'b1;
        in_word  = {9'o300, 4'd5};
        tick;
        in_word = {9'o301, 4'd6};
        tick;
        in_valid = 1'b0;
        tick;
        checkOutput("ar_pre_ir", 32'(ir3), 32'({9'o300, 4'd5}));
        checkOutput("ar_pre_cnt", 32'(q_count3), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_ir", 32'(ir3), 32'd0);
        checkOutput("ar_cnt", 32'(q_count3), 32'd0);
        checkOutput("ar_ready", 32'(in_ready3), 32'd1);
        checkOutput("ar_en", 32'(dram_en3), 32'd0);
        checkOutput("ar_valid", 32'(disp_valid3), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        tick;
        checkOutput("ar_post_cnt", 32'(q_count3), 32'd0);
        checkOutput("ar_post_en", 32'(dram_en3), 32'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
